mc_ctrl: RTL

Multicycle control sequencer for the 32-bit MIPS datapath. It replaces the free-running clk2/clk3 phase strobes with a single-clock FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives every datapath enable and mux select, and handshakes with a shared instruction/data memory port that may insert wait states. It sits beside `datapath`, takes the opcode and ALU zero flag back from it, and exposes state and a retired-instruction counter for bench `$display` tracing.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/mc_ctrl.sv | 82 ++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, sequencer state encoding and datapath select encodings shared by mc_ctrl and datapath
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BR     = 2'd1;
    localparam logic [1:0] PC_JMP    = 2'd2;
    function automatic logic is_legal(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW, OP_HALT};
    endfunction
endpackage

// File: rtl/mc_ctrl.sv
// mc_ctrl: single-clock multicycle sequencer driving the MIPS datapath and a wait-state memory port
module mc_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             rf_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);
    state_t     state_q, state_d;
    logic [5:0] op_q;
    logic       fetch, exec, mem, wb, retire;

    always_comb begin
        fetch      = state_q == S_FETCH;
        exec       = state_q == S_EXEC;
        mem        = state_q == S_MEM;
        wb         = state_q == S_WB;
        state      = state_q;
        mem_req    = fetch || mem;
        iord       = mem;
        mem_we     = mem && op_q == OP_SW;
        ir_we      = fetch && mem_ack;
        pc_we      = (fetch && mem_ack) || (exec && (op_q == OP_J || (op_q == OP_BEQ && zero)));
        pc_src     = exec && op_q == OP_BEQ ? PC_BR : exec && op_q == OP_J ? PC_JMP : PC_SEQ;
        alu_src_b  = exec && (op_q == OP_ADDI || op_q == OP_LW || op_q == OP_SW);
        alu_op     = exec && op_q == OP_RTYPE ? ALU_FUNCT : exec && op_q == OP_BEQ ? ALU_SUB : ALU_ADD;
        rf_we      = wb;
        reg_dst    = wb && op_q == OP_RTYPE;
        mem_to_reg = wb && op_q == OP_LW;
        halted     = state_q == S_HALT;
        illegal    = exec && !is_legal(op_q);
        retire     = wb || (mem && mem_ack && op_q == OP_SW)
                     || (exec && (op_q == OP_BEQ || op_q == OP_J || op_q == OP_HALT));
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ack ? S_DECODE : S_FETCH;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = op_q == OP_RTYPE || op_q == OP_ADDI ? S_WB
                              : op_q == OP_LW || op_q == OP_SW ? S_MEM
                              : op_q == OP_HALT ? S_HALT : S_FETCH;
            S_MEM:    state_d = !mem_ack ? S_MEM : op_q == OP_SW ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= opcode;
            if (retire) retired <= retired + 1'b1;
        end
    end
endmodule
